vga_sprite_engine: RTL and testbench

// - Parametrised successor to the single-ship/bullet display: NUM_OBJ generic rectangular sprites.
// - Each sprite has its own position, size, colour and enable.
// - Writes land in shadow registers; they are committed to the active set once per frame at vblank.
// - Fixed priority, per-frame sticky collision detection, readable status, collision IRQ.
// - Avalon-MM slave (8-bit) driving the DE1 VGA DAC via vga_counters.

---
 rtl/vga_sprite_pkg.sv | 44 ++++
 rtl/vga_counters.sv | 56 +++++
 rtl/vga_sprite_engine_sprite_hit.sv | 26 ++
 rtl/vga_sprite_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_vga_sprite_engine.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_sprite_pkg.sv
// Shared types, register offsets and colour helper
// for the VGA sprite engine.
package vga_sprite_pkg;

    // Storage width of the size registers; the engine masks to SIZE_W.
    localparam int SPR_SZ_W = 8;

    localparam logic [2:0] OFF_XLO  = 3'd0;
    localparam logic [2:0] OFF_XHI  = 3'd1;
    localparam logic [2:0] OFF_YLO  = 3'd2;
    localparam logic [2:0] OFF_YHI  = 3'd3;
    localparam logic [2:0] OFF_W    = 3'd4;
    localparam logic [2:0] OFF_H    = 3'd5;
    localparam logic [2:0] OFF_COL  = 3'd6;
    localparam logic [2:0] OFF_CTRL = 3'd7;

    localparam logic [2:0] G_BGR  = 3'd0;
    localparam logic [2:0] G_BGG  = 3'd1;
    localparam logic [2:0] G_BGB  = 3'd2;
    localparam logic [2:0] G_CTRL = 3'd3;
    localparam logic [2:0] G_STLO = 3'd4;
    localparam logic [2:0] G_STHI = 3'd5;
    localparam logic [2:0] G_FRM  = 3'd6;
    localparam logic [2:0] G_CLR  = 3'd7;

    localparam logic [23:0] BG_RESET = 24'h000020;

    typedef struct packed {
        logic [9:0]          x;
        logic [9:0]          y;
        logic [SPR_SZ_W-1:0] w;
        logic [SPR_SZ_W-1:0] h;
        logic [7:0]          colour;
        logic                en;
    } sprite_t;

    // RGB332 to RGB888 by bit replication.
    function automatic logic [23:0] rgb332_expand(input logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6],
                c[4:2], c[4:2], c[4:3],
                c[1:0], c[1:0], c[1:0], c[1:0]};
    endfunction

endpackage

// File: rtl/vga_counters.sv
// VGA raster timing: hcount runs at 2x pixel rate,
// vcount per line; sync/blank decoded from the counters.
module vga_counters #(
    parameter logic [10:0] HACTIVE = 11'd1280,
    parameter logic [10:0] HFRONT  = 11'd32,
    parameter logic [10:0] HSYNC   = 11'd192,
    parameter logic [10:0] HBACK   = 11'd96,
    parameter logic [9:0]  VACTIVE = 10'd480,
    parameter logic [9:0]  VFRONT  = 10'd10,
    parameter logic [9:0]  VSYNC   = 10'd2,
    parameter logic [9:0]  VBACK   = 10'd33
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_n,
    output logic        VGA_SYNC_n
);

    localparam logic [10:0] HTOTAL = HACTIVE + HFRONT + HSYNC + HBACK;
    localparam logic [9:0]  VTOTAL = VACTIVE + VFRONT + VSYNC + VBACK;
    localparam logic [10:0] HS_ON  = HACTIVE + HFRONT;
    localparam logic [10:0] HS_OFF = HACTIVE + HFRONT + HSYNC;
    localparam logic [9:0]  VS_ON  = VACTIVE + VFRONT;
    localparam logic [9:0]  VS_OFF = VACTIVE + VFRONT + VSYNC;

    logic end_line;
    logic end_field;

    assign end_line  = (hcount == HTOTAL - 11'd1);
    assign end_field = (vcount == VTOTAL - 10'd1);

    // Horizontal and vertical raster counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (end_line) begin
            hcount <= '0;
            vcount <= end_field ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 11'd1;
        end
    end

    assign VGA_HS      = !((hcount >= HS_ON) && (hcount < HS_OFF));
    assign VGA_VS      = !((vcount >= VS_ON) && (vcount < VS_OFF));
    assign VGA_BLANK_n = (hcount < HACTIVE) && (vcount < VACTIVE);
    assign VGA_SYNC_n  = 1'b0;
    assign VGA_CLK     = hcount[0];

endmodule

// File: rtl/vga_sprite_engine_sprite_hit.sv
// Combinational hit test of one sprite rectangle
// against the current pixel; sums are 11-bit so no wrap.
module sprite_hit
    import vga_sprite_pkg::*;
(
    input  sprite_t    spr_i,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    output logic       hit_o
);

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_x;
    logic        in_y;

    // Half-open box test [X, X+W+1) x [Y, Y+H+1).
    always_comb begin
        x_end = {1'b0, spr_i.x} + {3'b0, spr_i.w} + 11'd1;
        y_end = {1'b0, spr_i.y} + {3'b0, spr_i.h} + 11'd1;
        in_x  = (x_i >= spr_i.x) && ({1'b0, x_i} < x_end);
        in_y  = (y_i >= spr_i.y) && ({1'b0, y_i} < y_end);
        hit_o = spr_i.en && in_x && in_y;
    end

endmodule

// File: rtl/vga_sprite_engine.sv
// NUM_OBJ-sprite VGA engine with shadow/active register
// sets, priority mixing, sticky collisions and Avalon access.
module vga_sprite_engine
    import vga_sprite_pkg::*;
#(
    parameter int          NUM_OBJ     = 8,
    parameter int          SIZE_W      = 6,
    parameter logic [9:0]  COMMIT_LINE = 10'd480,
    parameter logic [10:0] H_ACTIVE    = 11'd1280,
    parameter logic [10:0] H_FRONT     = 11'd32,
    parameter logic [10:0] H_SYNC      = 11'd192,
    parameter logic [10:0] H_BACK      = 11'd96,
    parameter logic [9:0]  V_ACTIVE    = 10'd480,
    parameter logic [9:0]  V_FRONT     = 10'd10,
    parameter logic [9:0]  V_SYNC      = 10'd2,
    parameter logic [9:0]  V_BACK      = 10'd33,
    localparam int         AW          = $clog2(NUM_OBJ * 8 + 8)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          chipselect,
    input  logic          write,
    input  logic          read,
    input  logic [AW-1:0] address,
    input  logic [7:0]    writedata,
    output logic [7:0]    readdata,
    output logic          irq,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_CLK,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_n,
    output logic          VGA_SYNC_n
);

    localparam logic [7:0] SZ_MASK = 8'((1 << SIZE_W) - 1);

    logic [10:0] hcount_w;
    logic [9:0]  vcount_w;
    logic        cnt_clk, cnt_hs, cnt_vs, cnt_blank_n, cnt_sync_n;

    vga_counters #(
        .HACTIVE(H_ACTIVE), .HFRONT(H_FRONT),
        .HSYNC(H_SYNC),     .HBACK(H_BACK),
        .VACTIVE(V_ACTIVE), .VFRONT(V_FRONT),
        .VSYNC(V_SYNC),     .VBACK(V_BACK)
    ) u_cnt (
        .clk(clk), .reset(reset),
        .hcount(hcount_w), .vcount(vcount_w),
        .VGA_CLK(cnt_clk), .VGA_HS(cnt_hs), .VGA_VS(cnt_vs),
        .VGA_BLANK_n(cnt_blank_n), .VGA_SYNC_n(cnt_sync_n)
    );

    sprite_t     shadow_q [NUM_OBJ];
    sprite_t     shadow_d [NUM_OBJ];
    sprite_t     active_q [NUM_OBJ];
    sprite_t     active_d [NUM_OBJ];
    logic [23:0] bg_sh_q, bg_sh_d, bg_act_q, bg_act_d;
    logic [1:0]  gctrl_q, gctrl_d;
    logic [15:0] status_q, status_d;
    logic [NUM_OBJ-1:0] acc_q, acc_d;
    logic [7:0]  frame_q, frame_d;
    logic [7:0]  readdata_q, readdata_d;
    logic [23:0] rgb_q, rgb_d;
    logic        vclk_q, hs_q, vs_q, blank_n_q, sync_n_q;

    logic [AW-4:0]      idx;
    logic [2:0]         off;
    int                 idx_n;
    logic               wr, rd, is_glb, commit, multi;
    logic [NUM_OBJ-1:0] hits;

    assign idx    = address[AW-1:3];
    assign off    = address[2:0];
    assign idx_n  = 32'(idx);
    assign wr     = chipselect && write;
    assign rd     = chipselect && read;
    assign is_glb = (idx_n == NUM_OBJ);
    assign commit = (hcount_w == 11'd0) && (vcount_w == COMMIT_LINE);

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
        sprite_hit u_hit (
            .spr_i(active_q[g]),
            .x_i  (hcount_w[10:1]),
            .y_i  (vcount_w),
            .hit_o(hits[g])
        );
    end

    assign multi = |(hits & (hits - NUM_OBJ'(1)));

    // Register writes, frame commit, collision accounting.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        bg_sh_d  = bg_sh_q;
        bg_act_d = bg_act_q;
        gctrl_d  = gctrl_q;
        acc_d    = acc_q;
        frame_d  = frame_q;
        status_d = status_q;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (wr && idx_n == i) begin
                case (off)
                    OFF_XLO:  shadow_d[i].x[7:0] = writedata;
                    OFF_XHI:  shadow_d[i].x[9:8] = writedata[1:0];
                    OFF_YLO:  shadow_d[i].y[7:0] = writedata;
                    OFF_YHI:  shadow_d[i].y[9:8] = writedata[1:0];
                    OFF_W:    shadow_d[i].w = writedata & SZ_MASK;
                    OFF_H:    shadow_d[i].h = writedata & SZ_MASK;
                    OFF_COL:  shadow_d[i].colour = writedata;
                    default:  shadow_d[i].en = writedata[0];
                endcase
            end
        end
        if (wr && is_glb) begin
            case (off)
                G_BGR:   bg_sh_d[23:16] = writedata;
                G_BGG:   bg_sh_d[15:8]  = writedata;
                G_BGB:   bg_sh_d[7:0]   = writedata;
                G_CTRL:  gctrl_d = writedata[1:0];
                default: ;
            endcase
        end
        if (cnt_blank_n && multi) begin
            acc_d = acc_q | hits;
        end
        if (wr && is_glb && off == G_CLR) begin
            status_d = '0;
        end
        if (commit) begin
            status_d = status_d | 16'(acc_q);
            acc_d    = '0;
            frame_d  = frame_q + 8'd1;
            if (!gctrl_q[0]) begin
                active_d = shadow_q;
                bg_act_d = bg_sh_q;
            end
        end
    end

    // Read mux; readdata holds between reads.
    always_comb begin
        readdata_d = readdata_q;
        if (rd) begin
            readdata_d = '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (idx_n == i) begin
                    case (off)
                        OFF_XLO:  readdata_d = shadow_q[i].x[7:0];
                        OFF_XHI:  readdata_d = {6'd0, shadow_q[i].x[9:8]};
                        OFF_YLO:  readdata_d = shadow_q[i].y[7:0];
                        OFF_YHI:  readdata_d = {6'd0, shadow_q[i].y[9:8]};
                        OFF_W:    readdata_d = shadow_q[i].w;
                        OFF_H:    readdata_d = shadow_q[i].h;
                        OFF_COL:  readdata_d = shadow_q[i].colour;
                        default:  readdata_d = {7'd0, shadow_q[i].en};
                    endcase
                end
            end
            if (is_glb) begin
                case (off)
                    G_BGR:   readdata_d = bg_sh_q[23:16];
                    G_BGG:   readdata_d = bg_sh_q[15:8];
                    G_BGB:   readdata_d = bg_sh_q[7:0];
                    G_CTRL:  readdata_d = {6'd0, gctrl_q};
                    G_STLO:  readdata_d = status_q[7:0];
                    G_STHI:  readdata_d = status_q[15:8];
                    G_FRM:   readdata_d = frame_q;
                    default: readdata_d = '0;
                endcase
            end
        end
    end

    // Priority mix: lowest index wins, background otherwise.
    always_comb begin
        rgb_d = bg_act_q;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hits[i]) begin
                rgb_d = rgb332_expand(active_q[i].colour);
            end
        end
        if (!cnt_blank_n) begin
            rgb_d = '0;
        end
    end

    // State registers and the one-clock output pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            bg_sh_q    <= BG_RESET;
            bg_act_q   <= BG_RESET;
            gctrl_q    <= '0;
            acc_q      <= '0;
            status_q   <= '0;
            frame_q    <= '0;
            readdata_q <= '0;
            rgb_q      <= '0;
            vclk_q     <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            blank_n_q  <= 1'b0;
            sync_n_q   <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            bg_sh_q    <= bg_sh_d;
            bg_act_q   <= bg_act_d;
            gctrl_q    <= gctrl_d;
            acc_q      <= acc_d;
            status_q   <= status_d;
            frame_q    <= frame_d;
            readdata_q <= readdata_d;
            rgb_q      <= rgb_d;
            vclk_q     <= cnt_clk;
            hs_q       <= cnt_hs;
            vs_q       <= cnt_vs;
            blank_n_q  <= cnt_blank_n;
            sync_n_q   <= cnt_sync_n;
        end
    end

    assign readdata    = readdata_q;
    assign irq         = gctrl_q[1] && (|status_q);
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign VGA_CLK     = vclk_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_n = blank_n_q;
    assign VGA_SYNC_n  = sync_n_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine on a shrunk raster
// (64x40 visible) so several frames fit in a short run.
module tb_vga_sprite_engine;

    localparam int HTOT  = 144;
    localparam int VTOT  = 44;
    localparam int FRAME = HTOT * VTOT;
    localparam logic [6:0] G = 7'd64;

    logic       clk, reset, chipselect, write, read;
    logic [6:0] address;
    logic [7:0] writedata, readdata;
    logic       irq;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

    int n_assert = 0;
    int n_fail   = 0;
    int hm = 0;
    int vm = 0;
    logic [7:0] d;

    vga_sprite_engine #(
        .NUM_OBJ(8), .SIZE_W(6), .COMMIT_LINE(10'd40),
        .H_ACTIVE(11'd128), .H_FRONT(11'd4),
        .H_SYNC(11'd8),     .H_BACK(11'd4),
        .V_ACTIVE(10'd40),  .V_FRONT(10'd1),
        .V_SYNC(10'd1),     .V_BACK(10'd2)
    ) dut (
        .clk(clk), .reset(reset),
        .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata),
        .readdata(readdata), .irq(irq),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference raster position held by the DUT counters.
    always @(posedge clk) begin
        if (reset) begin
            hm <= 0;
            vm <= 0;
        end else if (hm == HTOT - 1) begin
            hm <= 0;
            vm <= (vm == VTOT - 1) ? 0 : vm + 1;
        end else begin
            hm <= hm + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] v);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = v;
        step();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] v);
        chipselect = 1'b1; read = 1'b1; address = a;
        step();
        v = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    // Run until counters reach (hh,vv), then one clk so outputs show it.
    task automatic go(input int hh, input int vv);
        int k;
        k = 0;
        while (!(hm == hh && vm == vv) && k < 2 * FRAME) begin
            step();
            k++;
        end
        if (k >= 2 * FRAME) begin
            n_assert++;
            n_fail++;
            $error("FAIL go_timeout: observed %0d,%0d expected %0d,%0d",
                   hm, vm, hh, vv);
        end
        step();
    endtask

    task automatic pix(input string tag, input logic [7:0] r,
                       input logic [7:0] g, input logic [7:0] b);
        chk({tag, "_r"}, VGA_R, r);
        chk({tag, "_g"}, VGA_G, g);
        chk({tag, "_b"}, VGA_B, b);
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0;
        repeat (3) step();
        chk("rst_readdata", readdata, 8'h00);
        chk("rst_irq", irq, 1'b0);
        pix("rst_pix", 8'h00, 8'h00, 8'h00);
        reset = 1'b0;

        // Frame 0: idle background, then program sprite 0.
        go(20, 5);
        pix("idle_bg", 8'h00, 8'h00, 8'h20);
        rd(G + 7'd6, d); chk("frm0", d, 8'd0);
        rd(G + 7'd4, d); chk("stat0", d, 8'h00);
        chk("irq0", irq, 1'b0);
        wr(7'd0, 8'd20); wr(7'd1, 8'd0);
        wr(7'd2, 8'd10); wr(7'd3, 8'd0);
        wr(7'd4, 8'd7);  wr(7'd5, 8'd3);
        wr(7'd6, 8'hE0); wr(7'd7, 8'h01);
        go(40, 10);
        pix("precommit", 8'h00, 8'h00, 8'h20);
        go(0, 40);
        rd(G + 7'd6, d); chk("frm1", d, 8'd1);

        // Frame 1: sprite 0 at (20,10) 8x4.
        go(40, 10);  pix("s0_tl", 8'hFF, 8'h00, 8'h00);
        go(56, 10);  pix("s0_right", 8'h00, 8'h00, 8'h20);
        go(54, 13);  pix("s0_br", 8'hFF, 8'h00, 8'h00);
        go(40, 14);  pix("s0_below", 8'h00, 8'h00, 8'h20);
        go(130, 14);
        pix("blank", 8'h00, 8'h00, 8'h00);
        chk("blank_n", VGA_BLANK_n, 1'b0);
        wr(G + 7'd3, 8'h01);
        wr(7'd0, 8'd40);
        go(0, 40);

        // Frames 2-3: hold keeps old position.
        go(40, 10);  chk("hold1_old", VGA_R, 8'hFF);
        go(80, 10);  chk("hold1_new", VGA_R, 8'h00);
        go(0, 40);
        go(40, 10);  chk("hold2_old", VGA_R, 8'hFF);
        wr(G + 7'd3, 8'h00);
        go(0, 40);

        // Frame 4: moved; set up overlap of sprites 0 and 1.
        go(40, 10);  chk("moved_old", VGA_R, 8'h00);
        go(80, 10);  chk("moved_new", VGA_R, 8'hFF);
        rd(G + 7'd6, d); chk("frm4", d, 8'd4);
        wr(7'd0, 8'd30); wr(7'd2, 8'd30);
        wr(7'd4, 8'd3);  wr(7'd5, 8'd3);
        wr(7'd8, 8'd32); wr(7'd9, 8'd0);
        wr(7'd10, 8'd32); wr(7'd11, 8'd0);
        wr(7'd12, 8'd3); wr(7'd13, 8'd3);
        wr(7'd14, 8'h1C); wr(7'd15, 8'h01);
        wr(G + 7'd3, 8'h02);
        go(0, 40);

        // Frame 5: priority and pending collision.
        go(66, 33);  pix("ovl", 8'hFF, 8'h00, 8'h00);
        go(70, 35);  pix("s1", 8'h00, 8'hFF, 8'h00);
        rd(G + 7'd4, d); chk("stat_pend", d, 8'h00);
        chk("irq_pend", irq, 1'b0);
        go(0, 40);

        // Frame 6: status merged; clear; set up clip sprites.
        rd(G + 7'd4, d); chk("stat_lo", d, 8'h03);
        rd(G + 7'd5, d); chk("stat_hi", d, 8'h00);
        chk("irq_set", irq, 1'b1);
        wr(G + 7'd7, 8'h00);
        rd(G + 7'd4, d); chk("stat_clr", d, 8'h00);
        chk("irq_clr", irq, 1'b0);
        wr(7'd7, 8'h00); wr(7'd15, 8'h00);
        wr(7'd16, 8'd60); wr(7'd17, 8'd0);
        wr(7'd18, 8'd20); wr(7'd19, 8'd0);
        wr(7'd20, 8'd15); wr(7'd21, 8'd0);
        wr(7'd22, 8'h03); wr(7'd23, 8'h01);
        wr(7'd24, 8'hFC); wr(7'd25, 8'hFF);
        wr(7'd26, 8'd21); wr(7'd27, 8'd0);
        wr(7'd28, 8'hFF); wr(7'd29, 8'd0);
        wr(7'd30, 8'h03); wr(7'd31, 8'h01);
        rd(7'd25, d); chk("xhi_mask", d, 8'h03);
        rd(7'd28, d); chk("w_mask", d, 8'h3F);
        go(0, 40);

        // Frame 7: sticky re-collision, clipping, read timing.
        rd(G + 7'd4, d); chk("stat_again", d, 8'h03);
        chk("irq_again", irq, 1'b1);
        go(0, 20);    pix("clip_x0", 8'h00, 8'h00, 8'h20);
        go(22, 20);   pix("clip_x11", 8'h00, 8'h00, 8'h20);
        go(120, 20);  pix("clip_x60", 8'h00, 8'h00, 8'hFF);
        go(126, 20);  pix("clip_x63", 8'h00, 8'h00, 8'hFF);
        go(0, 21);    pix("wrap_x0", 8'h00, 8'h00, 8'h20);
        go(100, 21);  pix("wrap_x50", 8'h00, 8'h00, 8'h20);
        chipselect = 1'b1; read = 1'b1; address = G + 7'd6;
        step();
        chk("rd_lat1", readdata, 8'd7);
        chipselect = 1'b0; read = 1'b0;
        step();
        chk("rd_hold", readdata, 8'd7);
        rd(7'd100, d); chk("rd_unmapped", d, 8'h00);
        rd(G + 7'd7, d); chk("rd_clr_reg", d, 8'h00);
        rd(G + 7'd3, d); chk("rd_gctrl", d, 8'h02);

        // Mid-line reset.
        go(40, 30);
        chk("irq_prerst", irq, 1'b1);
        reset = 1'b1;
        step();
        pix("midrst", 8'h00, 8'h00, 8'h00);
        chk("midrst_rd", readdata, 8'h00);
        chk("midrst_irq", irq, 1'b0);
        chk("midrst_h", dut.hcount_w, 11'd0);
        chk("midrst_v", dut.vcount_w, 10'd0);
        reset = 1'b0;
        rd(G + 7'd6, d); chk("rst_frm", d, 8'd0);
        rd(G + 7'd4, d); chk("rst_stat", d, 8'h00);
        go(120, 20);  pix("rst_bg", 8'h00, 8'h00, 8'h20);
        go(0, 40);
        rd(G + 7'd6, d); chk("rst_frm1", d, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
